// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz raster timing constants shared by the sync generator and the
// board renderer: screen extents, porch/sync widths, sync-window bounds, the
// default pixel clock divider and the 10-bit coordinate type.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // System clocks per pixel: 100 MHz / 4 = 25 MHz pixel rate.
  localparam int VGA_CLK_DIV = 4;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Inclusive sync-low windows in pixel / line coordinates.
  localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
  localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

  // True when v lies in the inclusive range [lo, hi].
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// 1-bit shift register of configurable depth with a configurable reset value.
// Used to retard hsync/vsync so they reach the connector on the same clock as
// the renderer's registered colour. DEPTH = 0 degenerates to a wire.
module sync_delay_line #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = clk ^ reset;
    assign q = d;
  end else begin : g_shift
    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift the new sample in at stage 0; the oldest sample leaves at the top.
    always_comb begin
      sr_d    = sr_q;
      sr_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end

    // Every stage holds the idle level while in reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        sr_q <= {DEPTH{RST_VAL}};
      end else begin
        sr_q <= sr_d;
      end
    end

    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster timing generator. Produces pixel coordinates x/y,
// the active-video flag en, a per-pixel tick, a frame-start pulse and the
// active-low hsync/vsync pins. All flags are registered from the next-state
// counter values so they change on the same edge as x/y.
// Optional feature macro: VGA_SYNC_ALIGN_EN -- when defined, hsync/vsync are
// delayed by SYNC_DLY clocks to match the renderer's ROM + colour register.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int SYNC_DLY = 2
) (
  input  logic   clk,
  input  logic   reset,
  output coord_t x,
  output coord_t y,
  output logic   en,
  output logic   pix_tick,
  output logic   hsync,
  output logic   vsync,
  output logic   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO    = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI    = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO    = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI    = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  coord_t           x_q, x_d;
  coord_t           y_q, y_d;
  logic             en_q, en_d;
  logic             pix_tick_q, pix_tick_d;
  logic             frame_start_q, frame_start_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             tick;
  logic             x_wrap;

  // Next-state counters and flags; flags look at the next-state coordinates
  // so they stay aligned with x/y after the register.
  always_comb begin
    tick          = (div_q == DIV_LAST);
    div_d         = tick ? '0 : div_q + 1'b1;
    x_wrap        = tick && (x_q == H_LAST);
    x_d           = x_q;
    y_d           = y_q;
    if (tick) begin
      x_d = x_wrap ? '0 : x_q + 1'b1;
    end
    if (x_wrap) begin
      y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end
    frame_start_d = x_wrap && (y_q == V_LAST);
    pix_tick_d    = tick;
    en_d          = (x_d < H_ACT_C) && (y_d < V_ACT_C);
    hs_d          = !in_window(x_d, HS_LO, HS_HI);
    vs_d          = !in_window(y_d, VS_LO, VS_HI);
  end

  // Timing state; reset abandons any partial line/frame and parks on (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      en_q          <= 1'b0;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      en_q          <= en_d;
      pix_tick_q    <= pix_tick_d;
      frame_start_q <= frame_start_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign en          = en_q;
  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;

`ifdef VGA_SYNC_ALIGN_EN
  sync_delay_line #(
    .DEPTH   (SYNC_DLY),
    .RST_VAL (1'b1)
  ) u_hsync_dly (
    .clk   (clk),
    .reset (reset),
    .d     (hs_q),
    .q     (hsync)
  );

  sync_delay_line #(
    .DEPTH   (SYNC_DLY),
    .RST_VAL (1'b1)
  ) u_vsync_dly (
    .clk   (clk),
    .reset (reset),
    .d     (vs_q),
    .q     (vsync)
  );
`else
  // Without alignment the delay depth has no effect.
  localparam int unused_sync_dly = SYNC_DLY;
  assign hsync = hs_q;
  assign vsync = vs_q;
`endif

endmodule
